// File: rtl/systolic_array_pkg.sv
// Shared constants and word type for the output-stationary systolic array.
package systolic_array_pkg;

  localparam int unsigned DEFAULT_N     = 2;
  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/systolic_array_pe.sv
// One multiply-accumulate cell: accumulates a_in*b_in and forwards both operands one hop.
module systolic_pe
  import systolic_array_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] acc
);

  // Product and sum both wrap modulo 2^WIDTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      acc   <= acc + WIDTH'(a_in * b_in);
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_array.sv
// N x N output-stationary systolic array; A streams rightwards, B streams downwards.
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N-1:0][WIDTH-1:0]          A,
  input  logic [N-1:0][WIDTH-1:0]          B,
  output logic [N-1:0][N-1:0][WIDTH-1:0]   Out
);

  // a_bus[i][j] is the a operand entering PE(i,j); column N is the row's spill-out.
  logic [N-1:0][N:0][WIDTH-1:0] a_bus;
  // b_bus[i][j] is the b operand entering PE(i,j); row N is the column's spill-out.
  logic [N:0][N-1:0][WIDTH-1:0] b_bus;
  logic [N-1:0][WIDTH-1:0]      a_tail;
  logic                         unused_edge;

  for (genvar e = 0; e < N; e++) begin : g_edge
    assign a_bus[e][0] = A[e];
    assign b_bus[0][e] = B[e];
    assign a_tail[e]   = a_bus[e][N];
  end

  // Operands leaving the far edges have no consumer.
  assign unused_edge = ^{a_tail, b_bus[N]};

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.WIDTH(WIDTH)) u_pe (
        .clock (clock),
        .reset (reset),
        .a_in  (a_bus[i][j]),
        .b_in  (b_bus[i][j]),
        .a_out (a_bus[i][j+1]),
        .b_out (b_bus[i+1][j]),
        .acc   (Out[i][j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench: per-cycle behavioural model plus literal end-result checks.
module tb_systolic_array;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                      reset2, reset4;
  logic [1:0][31:0]          A2, B2;
  logic [1:0][1:0][31:0]     Out2;
  logic [3:0][31:0]          A4, B4;
  logic [3:0][3:0][31:0]     Out4;

  int total = 0;
  int bad   = 0;

  systolic_array #(.N(2), .WIDTH(32)) dut2 (
    .clock(clock), .reset(reset2), .A(A2), .B(B2), .Out(Out2));
  systolic_array #(.N(4), .WIDTH(32)) dut4 (
    .clock(clock), .reset(reset4), .A(A4), .B(B4), .Out(Out4));

  // Model: PE(i,j) at edge n multiplies A[i] sampled j edges ago by B[j] sampled i edges ago.
  logic [31:0] ha [2][16][4];
  logic [31:0] hb [2][16][4];
  logic [31:0] macc [2][4][4];
  int          hn [2];

  task automatic mclear(input int d);
    hn[d] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) macc[d][i][j] = '0;
  endtask

  task automatic mstep(input int d, input int nn, input logic [3:0][31:0] a,
                       input logic [3:0][31:0] b);
    for (int i = 0; i < 4; i++) begin
      ha[d][hn[d] % 16][i] = a[i];
      hb[d][hn[d] % 16][i] = b[i];
    end
    for (int i = 0; i < nn; i++)
      for (int j = 0; j < nn; j++)
        if (hn[d] >= i && hn[d] >= j)
          macc[d][i][j] = macc[d][i][j] +
            ha[d][(hn[d] - j) % 16][i] * hb[d][(hn[d] - i) % 16][j];
    hn[d] = hn[d] + 1;
  endtask

  always @(posedge clock or posedge reset2)
    if (reset2) mclear(0);
    else        mstep(0, 2, 128'(A2), 128'(B2));

  always @(posedge clock or posedge reset4)
    if (reset4) mclear(1);
    else        mstep(1, 4, A4, B4);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("model2[%0d][%0d]", i, j), Out2[i][j], macc[0][i][j]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("model4[%0d][%0d]", i, j), Out4[i][j], macc[1][i][j]);
  end

  task automatic feed2(input logic [31:0] a1, input logic [31:0] a0,
                       input logic [31:0] b1, input logic [31:0] b0);
    A2[1] = a1; A2[0] = a0; B2[1] = b1; B2[0] = b0;
    @(posedge clock); #1;
  endtask

  task automatic chk2(input string name, input logic [31:0] e00, input logic [31:0] e01,
                      input logic [31:0] e10, input logic [31:0] e11);
    chk({name, "_00"}, Out2[0][0], e00);
    chk({name, "_01"}, Out2[0][1], e01);
    chk({name, "_10"}, Out2[1][0], e10);
    chk({name, "_11"}, Out2[1][1], e11);
  endtask

  task automatic pulse_reset2;
    reset2 = 1'b1;
    #1 chk2("reset_async", 0, 0, 0, 0);
    A2 = '0; B2 = '0;
    @(posedge clock); #1;
    reset2 = 1'b0;
  endtask

  logic [31:0] am [2][2];
  logic [31:0] bm [2][2];
  logic [31:0] cexp;
  logic [31:0] bid [4][4];

  initial begin
    reset2 = 1'b1; reset4 = 1'b1;
    A2 = '0; B2 = '0; A4 = '0; B4 = '0;

    // Reset held with toggling operands: outputs stay zero.
    repeat (6) begin
      #3;
      A2 = {$urandom, $urandom}; B2 = {$urandom, $urandom};
      A4 = {$urandom, $urandom, $urandom, $urandom};
      #1 chk2("reset_hold", 0, 0, 0, 0);
      chk("reset_hold4", Out4[3][3], 0);
    end
    @(posedge clock); #1;
    A2 = '0; B2 = '0; A4 = '0; B4 = '0;
    reset2 = 1'b0; reset4 = 1'b0;

    // Reference 2x2 product with latency checkpoints.
    feed2(0, 3, 0, 2);   chk2("lat_e0", 6, 0, 0, 0);
    feed2(4, 6, 1, 10);  chk2("lat_e1", 66, 3, 8, 0);
    feed2(5, 0, 8, 0);   chk2("lat_e2", 66, 51, 58, 4);
    feed2(0, 0, 0, 0);   chk2("final", 66, 51, 58, 44);
    repeat (3) feed2(0, 0, 0, 0);
    chk2("stable", 66, 51, 58, 44);

    // Wrap-around of product and accumulator.
    pulse_reset2();
    feed2(0, 32'hFFFF_FFFF, 0, 2);
    chk("wrap_once", Out2[0][0], 32'hFFFF_FFFE);
    feed2(0, 32'hFFFF_FFFF, 0, 2);
    chk("wrap_twice", Out2[0][0], 32'hFFFF_FFFC);
    repeat (3) feed2(0, 0, 0, 0);

    // Mid-operation reset: only the post-reset beat contributes.
    pulse_reset2();
    feed2(0, 3, 0, 2);
    feed2(4, 6, 1, 10);
    reset2 = 1'b1;
    #1 chk2("midreset", 0, 0, 0, 0);
    #2 reset2 = 1'b0;
    feed2(5, 0, 8, 0);
    repeat (3) feed2(0, 0, 0, 0);
    chk2("post_midreset", 0, 0, 0, 40);

    // Random properly-skewed products against plain matrix multiplication.
    for (int r = 0; r < 8; r++) begin
      pulse_reset2();
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++) begin
          am[i][k] = (r < 4) ? 32'($urandom_range(0, 255)) : 32'($urandom);
          bm[i][k] = (r < 4) ? 32'($urandom_range(0, 255)) : 32'($urandom);
        end
      for (int t = 0; t <= 2; t++) begin
        for (int i = 0; i < 2; i++) begin
          A2[i] = (t - i >= 0 && t - i < 2) ? am[i][t-i] : 32'd0;
          B2[i] = (t - i >= 0 && t - i < 2) ? bm[t-i][i] : 32'd0;
        end
        @(posedge clock); #1;
      end
      repeat (3) feed2(0, 0, 0, 0);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          cexp = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
          chk($sformatf("rand%0d_%0d%0d", r, i, j), Out2[i][j], cexp);
        end
    end

    // Unskewed random traffic: the model alone judges it.
    pulse_reset2();
    repeat (30) feed2($urandom, $urandom, $urandom, $urandom);
    feed2(0, 0, 0, 0);

    // 4x4 identity times B = B.
    reset4 = 1'b1; #1; reset4 = 1'b0;
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++) bid[rr][c] = 32'(4 * rr + c + 1);
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++) begin
        A4[i] = (t - i >= 0 && t - i < 4) ? ((t - i == i) ? 32'd1 : 32'd0) : 32'd0;
        B4[i] = (t - i >= 0 && t - i < 4) ? bid[t-i][i] : 32'd0;
      end
      @(posedge clock); #1;
      if (t == 8) chk("ident_e8_33", Out4[3][3], 0);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("ident_%0d%0d", i, j), Out4[i][j], bid[i][j]);
    A4 = '0; B4 = '0;
    repeat (3) begin @(posedge clock); #1; end
    chk("ident_stable_33", Out4[3][3], 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
